// File: rtl/sparc_mem_ctrl_if.sv
// Request/completion and RAM-side signals of the SPARC memory sequencer.
// Ports: slave = sequencer side, master = control unit plus RAM side.
interface sparc_mem_ctrl_if #(
    parameter int ADDR_W = 12
);
    logic              mov;
    logic              r_w;
    logic [1:0]        op_type;
    logic              sgn;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              MOC;
    logic              align_err;
    logic              mem_en;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  mov, r_w, op_type, sgn, addr, wdata,
        input  mem_rdata,
        output rdata, MOC, align_err,
        output mem_en, mem_we, mem_be,
        output mem_addr, mem_wdata
    );

    modport master (
        output mov, r_w, op_type, sgn, addr, wdata,
        output mem_rdata,
        input  rdata, MOC, align_err,
        input  mem_en, mem_we, mem_be,
        input  mem_addr, mem_wdata
    );
endinterface

// File: rtl/sparc_mem_ctrl.sv
// SPARC memory sequencer: alignment check, big-endian lane steering,
// wait states, load extension. Ports: Clk, Clr (async low), bus (slave).
module sparc_mem_ctrl #(
    parameter int ADDR_W      = 12,
    parameter int WAIT_STATES = 1
) (
    input logic             Clk,
    input logic             Clr,
    sparc_mem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t            state, state_n;
    logic [3:0]        cnt, cnt_n;
    logic              ld, ld_n;
    logic [1:0]        op, op_n;
    logic              sx, sx_n;
    logic [1:0]        off, off_n;
    logic [31:0]       rdata_q, rdata_n;
    logic              moc_q, moc_n;
    logic              aerr_q, aerr_n;
    logic              en_q, en_n;
    logic              we_q, we_n;
    logic [3:0]        be_q, be_n;
    logic [ADDR_W-3:0] maddr_q, maddr_n;
    logic [31:0]       wd_q, wd_n;

    logic              misal;
    logic [3:0]        be_req;
    logic [31:0]       wd_req;
    logic [7:0]        lane_b;
    logic [31:0]       ld_val;
    logic              unused_addr;

    // High address bits alias onto the RAM.
    assign unused_addr = ^bus.addr[31:ADDR_W];

    // Request decode from the live inputs, used only in IDLE.
    always_comb begin
        misal  = 1'b0;
        be_req = 4'b1111;
        wd_req = bus.wdata;
        unique case (1'b1)
            bus.op_type == 2'b00: begin
                be_req = 4'b1000 >> bus.addr[1:0];
                wd_req = {4{bus.wdata[7:0]}};
            end
            bus.op_type == 2'b01: begin
                misal  = bus.addr[0];
                be_req = bus.addr[1] ? 4'b0011 : 4'b1100;
                wd_req = {2{bus.wdata[15:0]}};
            end
            default: misal = |bus.addr[1:0];
        endcase
    end

    // Lane 0 (offset 00) is bits 31:24, so shift by (3-off)*8.
    always_comb begin
        lane_b = 8'(bus.mem_rdata >> {~off, 3'b000});
        ld_val = bus.mem_rdata;
        unique case (1'b1)
            op == 2'b00:
                ld_val = {{24{sx & lane_b[7]}}, lane_b};
            op == 2'b01:
                ld_val = off[1]
                    ? {{16{sx & bus.mem_rdata[15]}},
                       bus.mem_rdata[15:0]}
                    : {{16{sx & bus.mem_rdata[31]}},
                       bus.mem_rdata[31:16]};
            default: ld_val = bus.mem_rdata;
        endcase
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ld_n    = ld;
        op_n    = op;
        sx_n    = sx;
        off_n   = off;
        rdata_n = rdata_q;
        moc_n   = moc_q;
        aerr_n  = aerr_q;
        en_n    = en_q;
        we_n    = we_q;
        be_n    = be_q;
        maddr_n = maddr_q;
        wd_n    = wd_q;
        unique case (state)
            IDLE: begin
                if (bus.mov) begin
                    ld_n  = bus.r_w;
                    op_n  = bus.op_type;
                    sx_n  = bus.sgn;
                    off_n = bus.addr[1:0];
                    if (misal) begin
                        state_n = DONE;
                        moc_n   = 1'b1;
                        aerr_n  = 1'b1;
                    end else begin
                        state_n = ACCESS;
                        cnt_n   = 4'(WAIT_STATES);
                        en_n    = 1'b1;
                        be_n    = be_req;
                        maddr_n = bus.addr[ADDR_W-1:2];
                        wd_n    = wd_req;
                        // Zero wait states: first cycle is the strobe.
                        we_n    = ~bus.r_w & (WAIT_STATES == 0);
                    end
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    state_n = DONE;
                    en_n    = 1'b0;
                    we_n    = 1'b0;
                    moc_n   = 1'b1;
                    if (ld) rdata_n = ld_val;
                end else begin
                    cnt_n = cnt - 4'd1;
                    // Strobe lands in the final (cnt==0) cycle.
                    we_n  = ~ld & (cnt == 4'd1);
                end
            end
            DONE: begin
                if (!bus.mov) begin
                    state_n = IDLE;
                    moc_n   = 1'b0;
                    aerr_n  = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) state <= IDLE;
        else      state <= state_n;
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            cnt     <= '0;
            ld      <= 1'b0;
            op      <= '0;
            sx      <= 1'b0;
            off     <= '0;
            rdata_q <= '0;
            moc_q   <= 1'b0;
            aerr_q  <= 1'b0;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
            maddr_q <= '0;
            wd_q    <= '0;
        end else begin
            cnt     <= cnt_n;
            ld      <= ld_n;
            op      <= op_n;
            sx      <= sx_n;
            off     <= off_n;
            rdata_q <= rdata_n;
            moc_q   <= moc_n;
            aerr_q  <= aerr_n;
            en_q    <= en_n;
            we_q    <= we_n;
            be_q    <= be_n;
            maddr_q <= maddr_n;
            wd_q    <= wd_n;
        end
    end

    assign bus.rdata     = rdata_q;
    assign bus.MOC       = moc_q;
    assign bus.align_err = aerr_q;
    assign bus.mem_en    = en_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_be    = be_q;
    assign bus.mem_addr  = maddr_q;
    assign bus.mem_wdata = wd_q;
endmodule

// File: tb/tb_sparc_mem_ctrl.sv
// Bench for sparc_mem_ctrl: vector table, hand sequences, random ops.
// Two instances: one wait state (main) and three (reset abort).
module tb_sparc_mem_ctrl;
    localparam int AW = 12;
    localparam int NW = 1 << (AW - 2);

    logic Clk  = 1'b0;
    logic Clr1 = 1'b0;
    logic Clr3 = 1'b0;
    always #5 Clk = ~Clk;

    logic        sel     = 1'b0;
    logic        mov     = 1'b0;
    logic        r_w     = 1'b0;
    logic        sgn     = 1'b0;
    logic [1:0]  op_type = 2'b00;
    logic [31:0] addr    = '0;
    logic [31:0] wdata   = '0;

    sparc_mem_ctrl_if #(.ADDR_W(AW)) b1 ();
    sparc_mem_ctrl_if #(.ADDR_W(AW)) b3 ();

    sparc_mem_ctrl #(.ADDR_W(AW), .WAIT_STATES(1)) dut1 (
        .Clk(Clk), .Clr(Clr1), .bus(b1)
    );
    sparc_mem_ctrl #(.ADDR_W(AW), .WAIT_STATES(3)) dut3 (
        .Clk(Clk), .Clr(Clr3), .bus(b3)
    );

    assign b1.mov     = mov & ~sel;
    assign b3.mov     = mov & sel;
    assign b1.r_w     = r_w;
    assign b3.r_w     = r_w;
    assign b1.op_type = op_type;
    assign b3.op_type = op_type;
    assign b1.sgn     = sgn;
    assign b3.sgn     = sgn;
    assign b1.addr    = addr;
    assign b3.addr    = addr;
    assign b1.wdata   = wdata;
    assign b3.wdata   = wdata;

    function automatic logic [31:0] init_word(int i);
        return {16'hC0DE, 16'(i)};
    endfunction

    function automatic logic [31:0] lane_mask(logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    logic [31:0] ram1 [NW];
    logic [31:0] ram3 [NW];
    logic        inited = 1'b0;

    always @(posedge Clk) begin
        if (!inited) begin
            for (int i = 0; i < NW; i++) begin
                ram1[i] <= init_word(i);
                ram3[i] <= init_word(i);
            end
            inited <= 1'b1;
        end else begin
            if (b1.mem_en && b1.mem_we)
                ram1[b1.mem_addr] <=
                    (ram1[b1.mem_addr] & ~lane_mask(b1.mem_be)) |
                    (b1.mem_wdata & lane_mask(b1.mem_be));
            if (b3.mem_en && b3.mem_we)
                ram3[b3.mem_addr] <=
                    (ram3[b3.mem_addr] & ~lane_mask(b3.mem_be)) |
                    (b3.mem_wdata & lane_mask(b3.mem_be));
        end
    end

    assign b1.mem_rdata = ram1[b1.mem_addr];
    assign b3.mem_rdata = ram3[b3.mem_addr];

    wire          o_moc   = sel ? b3.MOC : b1.MOC;
    wire          o_aerr  = sel ? b3.align_err : b1.align_err;
    wire          o_en    = sel ? b3.mem_en : b1.mem_en;
    wire          o_we    = sel ? b3.mem_we : b1.mem_we;
    wire [3:0]    o_be    = sel ? b3.mem_be : b1.mem_be;
    wire [AW-3:0] o_maddr = sel ? b3.mem_addr : b1.mem_addr;
    wire [31:0]   o_mwd   = sel ? b3.mem_wdata : b1.mem_wdata;
    wire [31:0]   o_rdata = sel ? b3.rdata : b1.rdata;

    int          acc_n  = 0;
    int          we_n   = 0;
    int          en_cyc = 0;
    logic        en_d   = 1'b0;
    logic [3:0]  last_be = '0;
    logic [31:0] last_wd = '0;

    always @(posedge Clk) begin
        en_d <= o_en;
        if (o_en && !en_d) acc_n <= acc_n + 1;
        if (o_en) en_cyc <= en_cyc + 1;
        if (o_we) begin
            we_n    <= we_n + 1;
            last_be <= o_be;
            last_wd <= o_mwd;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: byte-addressed memory, big-endian multi-byte values.
    logic [7:0]  mdl [1 << AW];
    logic [31:0] exp_rd = '0;

    function automatic int op_size(logic [1:0] t);
        return (t == 2'd0) ? 1 : (t == 2'd1) ? 2 : 4;
    endfunction

    task automatic model(input logic rw,
                         input logic [1:0] t,
                         input logic sx,
                         input logic [31:0] a,
                         input logic [31:0] wd,
                         output logic ae,
                         output logic [3:0] be);
        int sz;
        int ba;
        logic [31:0] v;
        sz = op_size(t);
        ba = int'(a[AW-1:0]);
        ae = (ba % sz) != 0;
        be = '0;
        if (ae) return;
        for (int k = 0; k < sz; k++) be[3 - (ba % 4) - k] = 1'b1;
        if (rw) begin
            v = '0;
            for (int k = 0; k < sz; k++)
                v = (v << 8) | 32'(mdl[ba + k]);
            if (sx && sz < 4 && v[8*sz-1])
                v = v | ~(32'hFFFF_FFFF >> (32 - 8*sz));
            exp_rd = v;
        end else begin
            for (int k = 0; k < sz; k++)
                mdl[ba + k] = 8'(wd >> (8 * (sz - 1 - k)));
        end
    endtask

    task automatic run_op(input string nm,
                          input logic rw,
                          input logic [1:0] t,
                          input logic sx,
                          input logic [31:0] a,
                          input logic [31:0] wd,
                          input int hold,
                          input int ws,
                          output logic [31:0] rd,
                          output logic ae);
        int n;
        int a0;
        int w0;
        int e0;
        logic eae;
        logic [3:0] ebe;
        n  = 0;
        a0 = acc_n;
        w0 = we_n;
        e0 = en_cyc;
        model(rw, t, sx, a, wd, eae, ebe);
        @(posedge Clk); #1;
        mov = 1'b1; r_w = rw; op_type = t;
        sgn = sx; addr = a; wdata = wd;
        do begin
            @(posedge Clk); #1;
            n++;
            if (n == 1) begin
                r_w     = 1'($urandom);
                op_type = 2'($urandom);
                sgn     = 1'($urandom);
                addr    = $urandom;
                wdata   = $urandom;
            end
        end while (!o_moc && n < 40);
        chk({nm, " latency"}, 32'(n), 32'(eae ? 1 : ws + 2));
        rd = o_rdata;
        ae = o_aerr;
        chk({nm, " align_err"}, 32'(ae), 32'(eae));
        chk({nm, " rdata"}, rd, exp_rd);
        for (int i = 0; i < hold; i++) begin
            @(posedge Clk); #1;
            chk({nm, " moc hold"}, 32'(o_moc), 32'd1);
        end
        mov = 1'b0;
        @(posedge Clk); #1;
        chk({nm, " moc clear"}, 32'(o_moc), 32'd0);
        chk({nm, " aerr clear"}, 32'(o_aerr), 32'd0);
        chk({nm, " accesses"}, 32'(acc_n - a0), 32'(eae ? 0 : 1));
        chk({nm, " we pulses"}, 32'(we_n - w0),
            32'((!eae && !rw) ? 1 : 0));
        chk({nm, " en cycles"}, 32'(en_cyc - e0),
            32'(eae ? 0 : ws + 1));
        if (!eae && !rw)
            chk({nm, " be"}, 32'(last_be), 32'(ebe));
    endtask

    typedef struct {
        logic        rw;
        logic [1:0]  t;
        logic        sx;
        logic [31:0] a;
        logic [31:0] wd;
        int          hold;
        logic [31:0] rd;
        logic        ae;
        logic [3:0]  be;
        logic [31:0] mwd;
    } vec_t;

    vec_t tv [18];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        ae;
        logic        eae;
        logic [3:0]  ebe;
        logic [31:0] v;
        int          mc;
        int          w0;

        tv[0]  = '{0, 2, 0, 32'h010, 32'hDEADBEEF, 5,
                   32'h0, 0, 4'b1111, 32'hDEADBEEF};
        tv[1]  = '{1, 2, 0, 32'h010, 32'h0, 0,
                   32'hDEADBEEF, 0, 4'b0, 32'h0};
        tv[2]  = '{0, 0, 0, 32'h013, 32'h1234565A, 0,
                   32'hDEADBEEF, 0, 4'b0001, 32'h5A5A5A5A};
        tv[3]  = '{1, 2, 0, 32'h010, 32'h0, 0,
                   32'hDEADBE5A, 0, 4'b0, 32'h0};
        tv[4]  = '{1, 0, 1, 32'h010, 32'h0, 0,
                   32'hFFFFFFDE, 0, 4'b0, 32'h0};
        tv[5]  = '{1, 0, 0, 32'h010, 32'h0, 0,
                   32'h000000DE, 0, 4'b0, 32'h0};
        tv[6]  = '{1, 1, 1, 32'h012, 32'h0, 0,
                   32'hFFFFBE5A, 0, 4'b0, 32'h0};
        tv[7]  = '{1, 2, 0, 32'h012, 32'h0, 2,
                   32'hFFFFBE5A, 1, 4'b0, 32'h0};
        tv[8]  = '{0, 1, 0, 32'h011, 32'hFFFF, 0,
                   32'hFFFFBE5A, 1, 4'b0, 32'h0};
        tv[9]  = '{1, 2, 0, 32'h010, 32'h0, 0,
                   32'hDEADBE5A, 0, 4'b0, 32'h0};
        tv[10] = '{1, 3, 1, 32'hFFFFF010, 32'h0, 0,
                   32'hDEADBE5A, 0, 4'b0, 32'h0};
        tv[11] = '{0, 1, 0, 32'h022, 32'hABCD1234, 0,
                   32'hDEADBE5A, 0, 4'b0011, 32'h12341234};
        tv[12] = '{1, 1, 1, 32'h022, 32'h0, 0,
                   32'h00001234, 0, 4'b0, 32'h0};
        tv[13] = '{1, 0, 1, 32'h020, 32'h0, 0,
                   32'hFFFFFFC0, 0, 4'b0, 32'h0};
        tv[14] = '{1, 2, 0, 32'h020, 32'h0, 0,
                   32'hC0DE1234, 0, 4'b0, 32'h0};
        tv[15] = '{1, 1, 0, 32'h020, 32'h0, 0,
                   32'h0000C0DE, 0, 4'b0, 32'h0};
        tv[16] = '{0, 0, 0, 32'h1022, 32'h77, 0,
                   32'h0000C0DE, 0, 4'b0010, 32'h77777777};
        tv[17] = '{1, 2, 0, 32'h020, 32'h0, 0,
                   32'hC0DE7734, 0, 4'b0, 32'h0};

        for (int i = 0; i < (1 << AW); i++)
            mdl[i] = 8'(init_word(i / 4) >> (8 * (3 - i % 4)));

        // Reset state
        repeat (3) @(posedge Clk);
        #1;
        chk("rst rdata", o_rdata, 32'h0);
        chk("rst moc", 32'(o_moc), 32'd0);
        chk("rst aerr", 32'(o_aerr), 32'd0);
        chk("rst en", 32'(o_en), 32'd0);
        chk("rst we", 32'(o_we), 32'd0);
        chk("rst be", 32'(o_be), 32'd0);
        chk("rst maddr", 32'(o_maddr), 32'd0);
        chk("rst mwd", o_mwd, 32'h0);
        Clr1 = 1'b1;
        Clr3 = 1'b1;

        // Reset in the 2nd access cycle of a 3-wait-state store
        sel = 1'b1;
        w0  = we_n;
        @(posedge Clk); #1;
        mov = 1'b1; r_w = 1'b0; op_type = 2'd2;
        sgn = 1'b0; addr = 32'h010; wdata = 32'hDEADBEEF;
        @(posedge Clk); #1;
        chk("abort en", 32'(o_en), 32'd1);
        @(posedge Clk); #2;
        Clr3 = 1'b0;
        #1;
        chk("abort rdata", o_rdata, 32'h0);
        chk("abort moc", 32'(o_moc), 32'd0);
        chk("abort aerr", 32'(o_aerr), 32'd0);
        chk("abort en0", 32'(o_en), 32'd0);
        chk("abort we", 32'(o_we), 32'd0);
        chk("abort be", 32'(o_be), 32'd0);
        chk("abort maddr", 32'(o_maddr), 32'd0);
        chk("abort mwd", o_mwd, 32'h0);
        mov = 1'b0;
        repeat (6) @(posedge Clk);
        #1;
        Clr3 = 1'b1;
        chk("abort no we", 32'(we_n - w0), 32'd0);
        run_op("abort load", 1'b1, 2'd2, 1'b0, 32'h010, 32'h0,
               0, 3, rd, ae);
        chk("abort old data", rd, 32'hC0DE0004);

        // Vector table on the one-wait-state instance
        sel    = 1'b0;
        exp_rd = 32'h0;
        for (int i = 0; i < 18; i++) begin
            run_op($sformatf("v%0d", i), tv[i].rw, tv[i].t, tv[i].sx,
                   tv[i].a, tv[i].wd, tv[i].hold, 1, rd, ae);
            chk($sformatf("v%0d tbl rdata", i), rd, tv[i].rd);
            chk($sformatf("v%0d tbl aerr", i), 32'(ae), 32'(tv[i].ae));
            if (!tv[i].rw && !tv[i].ae) begin
                chk($sformatf("v%0d tbl be", i),
                    32'(last_be), 32'(tv[i].be));
                chk($sformatf("v%0d tbl mwd", i), last_wd, tv[i].mwd);
            end
        end

        // mov dropped during the access: completes, MOC for one cycle
        model(1'b1, 2'd2, 1'b0, 32'h010, 32'h0, eae, ebe);
        @(posedge Clk); #1;
        mov = 1'b1; r_w = 1'b1; op_type = 2'd2; addr = 32'h010;
        @(posedge Clk); #1;
        mov = 1'b0;
        mc  = 0;
        repeat (6) begin
            @(posedge Clk); #1;
            if (o_moc) mc++;
        end
        chk("viol moc cycles", 32'(mc), 32'd1);
        chk("viol rdata", o_rdata, 32'hDEADBE5A);

        // Random operations against the model
        for (int i = 0; i < 200; i++) begin
            logic [31:0] ra;
            ra = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0)
                ra = ra | ($urandom & 32'hFFFF_F000);
            run_op($sformatf("rnd%0d", i),
                   1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)),
                   ra, $urandom, int'($urandom_range(0, 2)),
                   1, rd, ae);
        end

        for (int w = 0; w < 16; w++) begin
            v = {mdl[4*w], mdl[4*w+1], mdl[4*w+2], mdl[4*w+3]};
            chk($sformatf("ram word %0d", w), ram1[w], v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
